// File: rtl/key_schedule_iter.sv
// Iterative AES-128 key expansion: emits round keys 0..10 one per accepted transfer,
// deriving each key from the previous one with a valid/ready handshake downstream.
module key_schedule_iter (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [127:0] key_in,
    input  logic         rk_ready,
    output logic [127:0] round_key,
    output logic [3:0]   rk_round,
    output logic         rk_valid,
    output logic         busy,
    output logic         done
);

    typedef enum logic {StIdle, StExpand} state_e;

    localparam logic [3:0] LastRound = 4'd10;

    // FIPS-197 S-box, entry 0 in the leftmost byte.
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[b];
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] r);
        logic [7:0] v;
        case (r)
            4'd1:    v = 8'h01;
            4'd2:    v = 8'h02;
            4'd3:    v = 8'h04;
            4'd4:    v = 8'h08;
            4'd5:    v = 8'h10;
            4'd6:    v = 8'h20;
            4'd7:    v = 8'h40;
            4'd8:    v = 8'h80;
            4'd9:    v = 8'h1b;
            4'd10:   v = 8'h36;
            default: v = 8'h00;
        endcase
        return v;
    endfunction

    state_e       state_q, state_d;
    logic [127:0] key_q, key_d;
    logic [3:0]   round_q, round_d;
    logic         valid_q, valid_d;

    logic [31:0]  w0, w1, w2, w3, rot, sub, t, n0, n1, n2, n3;
    logic [127:0] next_key;
    logic         transfer;

    always_comb begin
        w0       = key_q[127:96];
        w1       = key_q[95:64];
        w2       = key_q[63:32];
        w3       = key_q[31:0];
        rot      = {w3[23:0], w3[31:24]};
        sub      = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])};
        t        = sub ^ {rcon(round_q + 4'd1), 24'h000000};
        n0       = w0 ^ t;
        n1       = w1 ^ n0;
        n2       = w2 ^ n1;
        n3       = w3 ^ n2;
        next_key = {n0, n1, n2, n3};
    end

    assign transfer = valid_q & rk_ready;

    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        round_d = round_q;
        valid_d = valid_q;
        done    = 1'b0;
        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StExpand;
                    key_d   = key_in;
                    round_d = 4'd0;
                    valid_d = 1'b1;
                end
            end
            StExpand: begin
                // start is deliberately not looked at here, even on the final transfer.
                if (transfer) begin
                    if (round_q == LastRound) begin
                        state_d = StIdle;
                        valid_d = 1'b0;
                        done    = 1'b1;
                    end else begin
                        key_d   = next_key;
                        round_d = round_q + 4'd1;
                    end
                end
            end
            default: begin
                state_d = StIdle;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            key_q   <= '0;
            round_q <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            round_q <= round_d;
            valid_q <= valid_d;
        end
    end

    assign round_key = key_q;
    assign rk_round  = round_q;
    assign rk_valid  = valid_q;
    assign busy      = (state_q == StExpand);

endmodule

// File: tb/tb_key_schedule_iter.sv
// Directed bench for key_schedule_iter: FIPS-197 and all-zero key expansions with stalls,
// ignored starts, mid-sequence reset and a downstream addRoundKey check.
module tb_key_schedule_iter;

    logic         clk = 1'b0;
    logic         reset, start, rk_ready;
    logic [127:0] key_in;
    logic [127:0] round_key;
    logic [3:0]   rk_round;
    logic         rk_valid, busy, done;

    int n_tests  = 0;
    int n_failed = 0;

    logic [127:0] exp_key   [0:10];
    bit           exp_known [0:10];

    localparam logic [127:0] FipsKey = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c;
    localparam logic [127:0] ZeroKey = 128'h0;

    key_schedule_iter dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .key_in    (key_in),
        .rk_ready  (rk_ready),
        .round_key (round_key),
        .rk_round  (rk_round),
        .rk_valid  (rk_valid),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] want);
        n_tests++;
        if (got !== want) begin
            n_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_fips();
        exp_key[0]  = FipsKey;
        exp_key[1]  = 128'ha0fafe17_88542cb1_23a33939_2a6c7605;
        exp_key[2]  = 128'hf2c295f2_7a96b943_5935807a_7359f67f;
        exp_key[3]  = 128'h3d80477d_4716fe3e_1e237e44_6d7a883b;
        exp_key[4]  = 128'hef44a541_a8525b7f_b671253b_db0bad00;
        exp_key[5]  = 128'hd4d1c6f8_7c839d87_caf2b8bc_11f915bc;
        exp_key[6]  = 128'h6d88a37a_110b3efd_dbf98641_ca0093fd;
        exp_key[7]  = 128'h4e54f70e_5f5fc9f3_84a64fb2_4ea6dc4f;
        exp_key[8]  = 128'head27321_b58dbad2_312bf560_7f8d292f;
        exp_key[9]  = 128'hac7766f3_19fadc21_28d12941_575c006e;
        exp_key[10] = 128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6;
        for (int i = 0; i <= 10; i++) exp_known[i] = 1'b1;
    endtask

    task automatic load_zero();
        for (int i = 0; i <= 10; i++) exp_known[i] = 1'b0;
        exp_key[0]  = ZeroKey;
        exp_key[1]  = 128'h62636363_62636363_62636363_62636363;
        exp_key[10] = 128'hb4ef5bcb_3e92e211_23e951cf_6f8f188e;
        exp_known[0]  = 1'b1;
        exp_known[1]  = 1'b1;
        exp_known[10] = 1'b1;
    endtask

    task automatic start_key(input logic [127:0] k);
        key_in = k;
        start  = 1'b1;
        tick();
        start  = 1'b0;
    endtask

    // Walks rounds 0..10 with rk_ready high except for an optional 3-cycle stall.
    task automatic run_seq(input string name, input int stall_at, input int abort_at,
                           input int glitch_at);
        logic [127:0] data, arc_out;
        for (int r = 0; r <= 10; r++) begin
            if (r == abort_at) begin
                reset = 1'b1;
                tick();
                reset = 1'b0;
                check({name, " abort valid"}, 128'(rk_valid), 128'(0));
                check({name, " abort busy"}, 128'(busy), 128'(0));
                check({name, " abort key"}, round_key, 128'(0));
                check({name, " abort round"}, 128'(rk_round), 128'(0));
                tick();
                tick();
                check({name, " abort stays idle"}, 128'(rk_valid), 128'(0));
                return;
            end
            check($sformatf("%s r%0d valid", name, r), 128'(rk_valid), 128'(1));
            check($sformatf("%s r%0d busy", name, r), 128'(busy), 128'(1));
            check($sformatf("%s r%0d round", name, r), 128'(rk_round), 128'(r));
            if (exp_known[r])
                check($sformatf("%s r%0d key", name, r), round_key, exp_key[r]);
            if (r == stall_at) begin
                rk_ready = 1'b0;
                for (int s = 0; s < 3; s++) begin
                    tick();
                    check($sformatf("%s stall%0d key", name, s), round_key, exp_key[r]);
                    check($sformatf("%s stall%0d round", name, s), 128'(rk_round), 128'(r));
                    check($sformatf("%s stall%0d done", name, s), 128'(done), 128'(0));
                end
                rk_ready = 1'b1;
            end
            check($sformatf("%s r%0d done", name, r), 128'(done), 128'(r == 10));
            // Downstream addRoundKey: data XOR round key on every transfer.
            data    = {4{32'h0f1e2d3c}} ^ {16{8'(r * 17)}};
            arc_out = data ^ round_key;
            if (exp_known[r])
                check($sformatf("%s r%0d ark", name, r), arc_out, data ^ exp_key[r]);
            if (r == glitch_at || r == 10) begin
                key_in = 128'hdeadbeef_01234567_89abcdef_cafef00d;
                start  = 1'b1;
            end
            tick();
            start = 1'b0;
        end
        check({name, " end valid"}, 128'(rk_valid), 128'(0));
        check({name, " end busy"}, 128'(busy), 128'(0));
        check({name, " end done"}, 128'(done), 128'(0));
        check({name, " end key hold"}, round_key, exp_key[10]);
        check({name, " end round hold"}, 128'(rk_round), 128'(10));
        tick();
        tick();
        check({name, " idle key hold"}, round_key, exp_key[10]);
        check({name, " idle valid"}, 128'(rk_valid), 128'(0));
    endtask

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        rk_ready = 1'b1;
        key_in   = '0;
        tick();
        start = 1'b1;
        key_in = FipsKey;
        tick();
        start = 1'b0;
        check("reset valid", 128'(rk_valid), 128'(0));
        check("reset busy", 128'(busy), 128'(0));
        check("reset done", 128'(done), 128'(0));
        check("reset key", round_key, 128'(0));
        check("reset round", 128'(rk_round), 128'(0));
        reset = 1'b0;
        tick();
        check("idle no start", 128'(rk_valid), 128'(0));

        load_fips();
        start_key(FipsKey);
        run_seq("fips", -1, -1, -1);

        start_key(FipsKey);
        run_seq("stall", 4, -1, -1);

        load_zero();
        start_key(ZeroKey);
        run_seq("zero", -1, -1, 3);

        load_fips();
        start_key(FipsKey);
        run_seq("abort", -1, 6, -1);
        start_key(FipsKey);
        run_seq("restart", -1, -1, -1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
